maxpool_sched: RTL and testbench
================================

// Module: maxpool_sched
// PURPOSE
//  Sequencer between the postprocessor and the 2x2/stride-2 maxpool datapath. Counts the raster
//  pixel stream (channel group outermost, then row, then col) and generates row/col/chn coordinates
//  for maxpool. Selects pool or bypass per layer and produces the single write stream (data + OFM
//  address) to the buffer manager. Signals layer completion.
// PARAMETERS
//  W_SIZE     `W_SIZE        width of row/col/width/height fields
//  W_CHANNEL  `W_CHANNEL     width of tiled output-channel fields
//  OFM_DW     `FM_BUFFER_DW  pixel word width (4 x 8b channels)
//  OFM_AW     `FM_BUFFER_AW  OFM buffer address width
// PORTS
//  clk            in   1          clock
//  rstn           in   1          async active-low reset
//  i_start        in   1          layer start pulse; latches cfg in IDLE
//  q_width        in   W_SIZE     input width in pixels
//  q_height       in   W_SIZE     input height in pixels
//  q_channel_out  in   W_CHANNEL  tiled output channel groups (C)
//  q_mp_en        in   1          1=pool layer, 0=bypass
//  pp_data_vld    in   1          postprocessor pixel valid
//  pp_data        in   OFM_DW     postprocessor pixel
//  o_mp_vld       out  1          pixel valid to maxpool
//  o_mp_data      out  OFM_DW     pixel to maxpool
//  o_mp_row       out  W_SIZE     row of pixel
//  o_mp_col       out  W_SIZE     col of pixel
//  o_mp_chn       out  W_CHANNEL  channel group of pixel
//  mp_data_vld    in   1          maxpool result valid
//  mp_data        in   OFM_DW     maxpool result
//  mp_addr        in   OFM_AW     maxpool result address
//  o_wr_vld       out  1          write to buffer manager
//  o_wr_data      out  OFM_DW     write data
//  o_wr_addr      out  OFM_AW     write address
//  o_busy         out  1          layer in progress
//  o_done         out  1          1-cycle pulse with final write
//  o_err          out  2          sticky {cfg_err, overrun}
// BEHAVIOUR
//  - Reset: all outputs, counters and config regs 0; FSM=IDLE. Reset mid-layer aborts with no done.
//  - FSM IDLE->RUN on i_start when config valid; RUN->DRAIN on acceptance of the last pixel
//    (chn=C-1, row=H-1, col=W-1); DRAIN->IDLE when the final write issues (o_done=1 that cycle).
//  - Config valid: W,H,C nonzero; if q_mp_en, W and H even. Invalid start: stay IDLE, set cfg_err.
//  - i_start outside IDLE ignored. Config latched at start; q_* changes mid-layer are ignored.
//  - pp_data_vld in IDLE/DRAIN: pixel dropped, overrun set. Both error bits clear on accepted start.
//  - Counters: col wraps W-1->0 with row++; row wraps H-1->0 with chn++. Advance only on accepted pixel.
//  - Pool path: pixel accepted at edge T -> o_mp_vld/data/row/col/chn registered at T+1 carrying that
//    pixel's coordinates. o_mp_vld is held 0 in bypass.
//  - Bypass path: 2-stage data delay; address = byp_base[chn] running value. byp_base starts at chn
//    and adds C per pixel (channel-interleaved layout). It reloads on chn change.
//  - Output: o_wr_* registered from mp_data_vld/mp_data/mp_addr (pool) or the bypass delay line.
//    Latency input edge T -> o_wr_vld at T+3 in both modes. o_wr_data=0 and o_wr_addr=0 when
//    o_wr_vld=0.
//  - Pool layer writes W*H*C/4 words; bypass writes W*H*C. No backpressure: one write per cycle max.
//  - Final write = last pixel's output (pool: odd/odd position). o_done pulses with it; o_busy=1 in
//    RUN/DRAIN.
//  - Address arithmetic modulo 2^OFM_AW (wrap, no flag).
// TESTING
//  - Bypass W=2,H=2,C=1, pixels 0x01..0x04 back-to-back -> 4 writes, addr 0,1,2,3, data in order,
//    o_done with 4th.
//  - Bypass W=2,H=1,C=2 -> addresses chn0: 0,2; chn1: 1,3; o_done with 4th write.
//  - Pool W=4,H=2,C=1 -> o_mp_row/col sequence (0,0)..(1,3) one cycle after input; exactly 2 writes
//    pass through mp_*; o_done with 2nd.
//  - Pool start with W=3 -> stays IDLE, o_err=2'b10, o_busy=0; next valid start clears o_err.
//  - pp_data_vld in IDLE -> o_err=2'b01, no write. Bubbles inside RUN -> counters hold, latency
//    stays 3.
//  - rstn low mid-layer -> all outputs 0, IDLE, no o_done; fresh start runs normally.

Source files
------------

// File: rtl/maxpool_sched_if.sv
// ---------------------------------------------------------------------------
// maxpool_sched_if
//   Data-path bundle around the maxpool scheduler: the postprocessor pixel
//   stream in, the coordinate-tagged pixel stream to maxpool, the pooled
//   result stream back from maxpool, and the write stream to the buffer
//   manager.
//
//   Handshake: every stream is valid-only with no backpressure. A beat
//   transfers on each rising clk edge where its *_vld is high; the receiver
//   must always accept. Data/address fields are only meaningful with vld.
//
//   master : the scheduler side (consumes pp_* and mp_*, drives o_*)
//   slave  : the surrounding datapath / environment
//
//   pp_data_vld/pp_data              postprocessor pixel
//   o_mp_vld/data/row/col/chn        pixel + coordinates to maxpool
//   mp_data_vld/mp_data/mp_addr      maxpool result + OFM address
//   o_wr_vld/o_wr_data/o_wr_addr     write to buffer manager
// ---------------------------------------------------------------------------
interface maxpool_sched_if #(
   parameter int W_SIZE    = 8,
   parameter int W_CHANNEL = 5,
   parameter int OFM_DW    = 32,
   parameter int OFM_AW    = 12
);
   logic                 pp_data_vld;
   logic [OFM_DW-1:0]    pp_data;

   logic                 o_mp_vld;
   logic [OFM_DW-1:0]    o_mp_data;
   logic [W_SIZE-1:0]    o_mp_row;
   logic [W_SIZE-1:0]    o_mp_col;
   logic [W_CHANNEL-1:0] o_mp_chn;

   logic                 mp_data_vld;
   logic [OFM_DW-1:0]    mp_data;
   logic [OFM_AW-1:0]    mp_addr;

   logic                 o_wr_vld;
   logic [OFM_DW-1:0]    o_wr_data;
   logic [OFM_AW-1:0]    o_wr_addr;

   modport master (
      input  pp_data_vld, pp_data,
      input  mp_data_vld, mp_data, mp_addr,
      output o_mp_vld, o_mp_data, o_mp_row, o_mp_col, o_mp_chn,
      output o_wr_vld, o_wr_data, o_wr_addr
   );

   modport slave (
      output pp_data_vld, pp_data,
      output mp_data_vld, mp_data, mp_addr,
      input  o_mp_vld, o_mp_data, o_mp_row, o_mp_col, o_mp_chn,
      input  o_wr_vld, o_wr_data, o_wr_addr
   );
endinterface

// File: rtl/maxpool_sched.sv
// ---------------------------------------------------------------------------
// maxpool_sched
//   Sequencer between the postprocessor and the 2x2/stride-2 maxpool
//   datapath. Counts the raster pixel stream (channel group outermost, then
//   row, then col), tags pixels with coordinates for maxpool, selects pool or
//   bypass per layer and emits one write stream (data + OFM address).
//
//   clk, rstn        clock, asynchronous active-low reset
//   i_start          layer start pulse, accepted only in IDLE with valid cfg
//   q_width/height   layer size in pixels (latched at start)
//   q_channel_out    tiled output channel groups C (latched at start)
//   q_mp_en          1 = pool layer, 0 = bypass (latched at start)
//   bus              data-path streams (see maxpool_sched_if)
//   o_busy           layer in progress (RUN or DRAIN)
//   o_done           one-cycle pulse together with the final write
//   o_err            sticky {cfg_err, overrun}, cleared by an accepted start
//   o_dbg_state      current FSM state (0 IDLE, 1 RUN, 2 DRAIN)
//
//   Latency: a pixel driven into the cycle after edge T appears on o_mp_* after
//   edge T+1 and its write on o_wr_* after edge T+3 in both modes (maxpool is
//   expected to return its result one cycle after o_mp_*).
// ---------------------------------------------------------------------------
module maxpool_sched #(
   parameter int W_SIZE    = 8,
   parameter int W_CHANNEL = 5,
   parameter int OFM_DW    = 32,
   parameter int OFM_AW    = 12
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 i_start,
   input  logic [W_SIZE-1:0]    q_width,
   input  logic [W_SIZE-1:0]    q_height,
   input  logic [W_CHANNEL-1:0] q_channel_out,
   input  logic                 q_mp_en,
   maxpool_sched_if.master      bus,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [1:0]           o_err,
   output logic [1:0]           o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t               state;

   logic [W_SIZE-1:0]    cfg_w;
   logic [W_SIZE-1:0]    cfg_h;
   logic [W_CHANNEL-1:0] cfg_c;
   logic                 cfg_mp_en;

   logic [W_SIZE-1:0]    col;
   logic [W_SIZE-1:0]    row;
   logic [W_CHANNEL-1:0] chn;
   logic [OFM_AW-1:0]    byp_addr;

   logic                 err_cfg;
   logic                 err_ovr;

   // last-pixel tag travelling alongside the 3-stage output latency
   logic                 last_d1;
   logic                 last_d2;

   logic                 byp1_vld;
   logic [OFM_DW-1:0]    byp1_data;
   logic [OFM_AW-1:0]    byp1_addr;
   logic                 byp2_vld;
   logic [OFM_DW-1:0]    byp2_data;
   logic [OFM_AW-1:0]    byp2_addr;

   logic cfg_ok;
   logic start_ok;
   logic start_bad;
   logic accept;
   logic drop;
   logic col_last;
   logic row_last;
   logic chn_last;
   logic pix_last;
   logic pool_wr;

   // pooling needs whole 2x2 windows, so both dimensions must be even
   assign cfg_ok    = (q_width != '0) && (q_height != '0) && (q_channel_out != '0) &&
                      (!q_mp_en || (!q_width[0] && !q_height[0]));
   assign start_ok  = (state == S_IDLE) && i_start && cfg_ok;
   assign start_bad = (state == S_IDLE) && i_start && !cfg_ok;
   assign accept    = (state == S_RUN) && bus.pp_data_vld;
   assign drop      = (state != S_RUN) && bus.pp_data_vld;

   assign col_last  = (col == cfg_w - W_SIZE'(1));
   assign row_last  = (row == cfg_h - W_SIZE'(1));
   assign chn_last  = (chn == cfg_c - W_CHANNEL'(1));
   assign pix_last  = accept && col_last && row_last && chn_last;

   assign pool_wr   = cfg_mp_en && bus.mp_data_vld && (state != S_IDLE);

   assign o_err       = {err_cfg, err_ovr};
   assign o_dbg_state = state;

   // control: FSM, config latch, raster counters, error flags
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         cfg_w     <= '0;
         cfg_h     <= '0;
         cfg_c     <= '0;
         cfg_mp_en <= 1'b0;
         col       <= '0;
         row       <= '0;
         chn       <= '0;
         byp_addr  <= '0;
         err_cfg   <= 1'b0;
         err_ovr   <= 1'b0;
         last_d1   <= 1'b0;
         last_d2   <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
      end else begin
         o_done  <= 1'b0;
         last_d1 <= pix_last;
         last_d2 <= last_d1;

         if (start_bad) begin
            err_cfg <= 1'b1;
         end else if (start_ok) begin
            err_cfg <= 1'b0;
         end
         // a dropped pixel in the same cycle as a start still flags overrun
         err_ovr <= (err_ovr && !start_ok) || drop;

         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  cfg_w     <= q_width;
                  cfg_h     <= q_height;
                  cfg_c     <= q_channel_out;
                  cfg_mp_en <= q_mp_en;
                  col       <= '0;
                  row       <= '0;
                  chn       <= '0;
                  byp_addr  <= '0;
                  o_busy    <= 1'b1;
                  state     <= S_RUN;
               end
            end
            S_RUN: begin
               if (accept) begin
                  if (col_last) begin
                     col <= '0;
                     if (row_last) begin
                        row <= '0;
                        chn <= chn + W_CHANNEL'(1);
                        // channel-interleaved layout: next group starts at its own index
                        byp_addr <= OFM_AW'(chn) + OFM_AW'(1);
                     end else begin
                        row      <= row + W_SIZE'(1);
                        byp_addr <= byp_addr + OFM_AW'(cfg_c);
                     end
                  end else begin
                     col      <= col + W_SIZE'(1);
                     byp_addr <= byp_addr + OFM_AW'(cfg_c);
                  end
                  if (pix_last) begin
                     state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (last_d2) begin
                  o_done <= 1'b1;
                  o_busy <= 1'b0;
                  state  <= S_IDLE;
               end
            end
            default: begin
               state  <= S_IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

   // datapath: maxpool feed, bypass delay line, write output
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.o_mp_vld  <= 1'b0;
         bus.o_mp_data <= '0;
         bus.o_mp_row  <= '0;
         bus.o_mp_col  <= '0;
         bus.o_mp_chn  <= '0;
         byp1_vld      <= 1'b0;
         byp1_data     <= '0;
         byp1_addr     <= '0;
         byp2_vld      <= 1'b0;
         byp2_data     <= '0;
         byp2_addr     <= '0;
         bus.o_wr_vld  <= 1'b0;
         bus.o_wr_data <= '0;
         bus.o_wr_addr <= '0;
      end else begin
         if (accept && cfg_mp_en) begin
            bus.o_mp_vld  <= 1'b1;
            bus.o_mp_data <= bus.pp_data;
            bus.o_mp_row  <= row;
            bus.o_mp_col  <= col;
            bus.o_mp_chn  <= chn;
         end else begin
            bus.o_mp_vld  <= 1'b0;
            bus.o_mp_data <= '0;
            bus.o_mp_row  <= '0;
            bus.o_mp_col  <= '0;
            bus.o_mp_chn  <= '0;
         end

         // two bypass stages match the maxpool round trip
         if (accept && !cfg_mp_en) begin
            byp1_vld  <= 1'b1;
            byp1_data <= bus.pp_data;
            byp1_addr <= byp_addr;
         end else begin
            byp1_vld  <= 1'b0;
            byp1_data <= '0;
            byp1_addr <= '0;
         end
         byp2_vld  <= byp1_vld;
         byp2_data <= byp1_data;
         byp2_addr <= byp1_addr;

         // byp2 is all-zero in pool mode, so it can be merged without a select
         if (pool_wr) begin
            bus.o_wr_vld  <= 1'b1;
            bus.o_wr_data <= bus.mp_data;
            bus.o_wr_addr <= bus.mp_addr;
         end else begin
            bus.o_wr_vld  <= byp2_vld;
            bus.o_wr_data <= byp2_data;
            bus.o_wr_addr <= byp2_addr;
         end
      end
   end

endmodule

// File: tb/tb_maxpool_sched.sv
// ---------------------------------------------------------------------------
// tb_maxpool_sched
//   Drives layers of raster pixels into maxpool_sched, emulates the maxpool
//   block (2x2 lane-wise max, one cycle after o_mp_*, address = result index
//   within the layer) and checks every cycle against expectations computed
//   from the pixel stream: bypass address = (row*W+col)*C + chn, pool result
//   = max of the four window pixels, write after 3 cycles, done with the
//   last write, busy from start to done.
// ---------------------------------------------------------------------------
module tb_maxpool_sched;
   localparam int W_SIZE    = 8;
   localparam int W_CHANNEL = 5;
   localparam int OFM_DW    = 32;
   localparam int OFM_AW    = 12;
   localparam int NEVER     = 32'h7fff_ffff;

   // ---------------- clock / reset ----------------
   logic                 clk = 1'b0;
   logic                 rstn = 1'b0;
   logic                 i_start = 1'b0;
   logic [W_SIZE-1:0]    q_width = '0;
   logic [W_SIZE-1:0]    q_height = '0;
   logic [W_CHANNEL-1:0] q_channel_out = '0;
   logic                 q_mp_en = 1'b0;
   logic                 o_busy;
   logic                 o_done;
   logic [1:0]           o_err;
   logic [1:0]           o_dbg_state;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   maxpool_sched_if #(.W_SIZE(W_SIZE), .W_CHANNEL(W_CHANNEL), .OFM_DW(OFM_DW), .OFM_AW(OFM_AW)) bus ();

   maxpool_sched #(.W_SIZE(W_SIZE), .W_CHANNEL(W_CHANNEL), .OFM_DW(OFM_DW), .OFM_AW(OFM_AW)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .i_start       (i_start),
      .q_width       (q_width),
      .q_height      (q_height),
      .q_channel_out (q_channel_out),
      .q_mp_en       (q_mp_en),
      .bus           (bus),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_err         (o_err),
      .o_dbg_state   (o_dbg_state)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_err    = 0;
   int n_done   = 0;
   int busy_from  = NEVER;
   int busy_until = NEVER;
   int win_idx  = 0;

   // write expectation: {due_cycle[76:45], done[44], addr[43:32], data[31:0]}
   logic [76:0] exp_q[$];
   // maxpool feed expectation: {due[84:53], chn[52:48], row[47:40], col[39:32], data[31:0]}
   logic [84:0] mp_q[$];
   logic [43:0] wr_log[$];
   logic [15:0] mp_log[$];
   logic [31:0] img [0:3][0:7][0:7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] lmax(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = (a[i*8 +: 8] > b[i*8 +: 8]) ? a[i*8 +: 8] : b[i*8 +: 8];
      return r;
   endfunction

   // ---------------- maxpool emulation ----------------
   logic [31:0] acc [0:3][0:7];
   logic [11:0] stub_cnt;
   wire  [1:0]  ci = bus.o_mp_chn[1:0];
   wire  [2:0]  wi = bus.o_mp_col[3:1];

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.mp_data_vld <= 1'b0;
         bus.mp_data     <= '0;
         bus.mp_addr     <= '0;
         stub_cnt        <= '0;
      end else begin
         bus.mp_data_vld <= 1'b0;
         bus.mp_data     <= '0;
         bus.mp_addr     <= '0;
         if (i_start && !o_busy) stub_cnt <= '0;
         if (bus.o_mp_vld) begin
            if (!bus.o_mp_row[0] && !bus.o_mp_col[0]) begin
               acc[ci][wi] <= bus.o_mp_data;
            end else if (!(bus.o_mp_row[0] && bus.o_mp_col[0])) begin
               acc[ci][wi] <= lmax(acc[ci][wi], bus.o_mp_data);
            end else begin
               bus.mp_data_vld <= 1'b1;
               bus.mp_data     <= lmax(acc[ci][wi], bus.o_mp_data);
               bus.mp_addr     <= stub_cnt;
               stub_cnt        <= stub_cnt + 12'd1;
            end
         end
      end
   end

   // ---------------- compare process ----------------
   logic [76:0] e_w;
   logic [84:0] e_m;

   always @(negedge clk) begin
      if (bus.o_wr_vld) begin
         wr_log.push_back({bus.o_wr_addr, bus.o_wr_data});
         if (exp_q.size() == 0) begin
            check("wr_unexpected", 32'd1, 32'd0);
         end else begin
            e_w = exp_q.pop_front();
            check("wr_cycle", cyc, e_w[76:45]);
            check("wr_addr", 32'(bus.o_wr_addr), 32'(e_w[43:32]));
            check("wr_data", bus.o_wr_data, e_w[31:0]);
            check("done_with_wr", 32'(o_done), 32'(e_w[44]));
         end
      end else begin
         check("wr_idle_zero", 32'(|{bus.o_wr_data, bus.o_wr_addr}), 32'd0);
         check("done_without_wr", 32'(o_done), 32'd0);
         if (exp_q.size() > 0) begin
            e_w = exp_q[0];
            if (int'(e_w[76:45]) <= cyc) begin
               check("wr_missing", 32'd0, 32'd1);
               void'(exp_q.pop_front());
            end
         end
      end
      if (o_done) n_done++;

      if (bus.o_mp_vld) begin
         mp_log.push_back({bus.o_mp_row, bus.o_mp_col});
         if (mp_q.size() == 0) begin
            check("mp_unexpected", 32'd1, 32'd0);
         end else begin
            e_m = mp_q.pop_front();
            check("mp_cycle", cyc, e_m[84:53]);
            check("mp_chn", 32'(bus.o_mp_chn), 32'(e_m[52:48]));
            check("mp_row", 32'(bus.o_mp_row), 32'(e_m[47:40]));
            check("mp_col", 32'(bus.o_mp_col), 32'(e_m[39:32]));
            check("mp_data", bus.o_mp_data, e_m[31:0]);
         end
      end else if (mp_q.size() > 0) begin
         e_m = mp_q[0];
         if (int'(e_m[84:53]) <= cyc) begin
            check("mp_missing", 32'd0, 32'd1);
            void'(mp_q.pop_front());
         end
      end

      check("busy", 32'(o_busy), 32'((cyc >= busy_from) && (cyc < busy_until)));
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic abort_layer();
      bus.pp_data_vld = 1'b0;
      rstn = 1'b0;
      exp_q.delete();
      mp_q.delete();
      busy_from = NEVER;
      #2;
      check("abort_busy", 32'(o_busy), 32'd0);
      check("abort_state", 32'(o_dbg_state), 32'd0);
      check("abort_wr", 32'(bus.o_wr_vld), 32'd0);
      check("abort_mp", 32'(bus.o_mp_vld), 32'd0);
      check("abort_err", 32'(o_err), 32'd0);
      step();
      step();
      rstn = 1'b1;
      step();
   endtask

   task automatic run_layer(input int w, input int h, input int c, input bit mp,
                            input int bub, input bit seq, input int abort_at);
      int n = 0;
      int d;
      bit last;
      logic [31:0] pix;
      logic [31:0] m;
      win_idx = 0;
      q_width = W_SIZE'(w);
      q_height = W_SIZE'(h);
      q_channel_out = W_CHANNEL'(c);
      q_mp_en = mp;
      i_start = 1'b1;
      busy_from = cyc + 1;
      busy_until = NEVER;
      step();
      i_start = 1'b0;
      // config must be held internally from here on
      q_width = W_SIZE'($urandom);
      q_height = W_SIZE'($urandom);
      q_channel_out = W_CHANNEL'($urandom);
      q_mp_en = 1'($urandom);
      check("err_after_start", 32'(o_err), 32'd0);
      check("state_run", 32'(o_dbg_state), 32'd1);
      for (int ch = 0; ch < c; ch++) begin
         for (int r = 0; r < h; r++) begin
            for (int col = 0; col < w; col++) begin
               while ($urandom_range(0, 99) < bub) begin
                  bus.pp_data_vld = 1'b0;
                  i_start = ($urandom_range(0, 5) == 0);
                  step();
               end
               i_start = 1'b0;
               if (abort_at == n) begin
                  abort_layer();
                  return;
               end
               pix = seq ? 32'(n + 1) : $urandom;
               img[ch][r][col] = pix;
               d = cyc;
               last = (ch == c - 1) && (r == h - 1) && (col == w - 1);
               bus.pp_data_vld = 1'b1;
               bus.pp_data = pix;
               if (mp) begin
                  mp_q.push_back({32'(d + 1), 5'(ch), 8'(r), 8'(col), pix});
                  if ((r % 2 == 1) && (col % 2 == 1)) begin
                     m = lmax(lmax(img[ch][r-1][col-1], img[ch][r-1][col]),
                              lmax(img[ch][r][col-1], pix));
                     exp_q.push_back({32'(d + 3), last, 12'(win_idx), m});
                     win_idx++;
                  end
               end else begin
                  exp_q.push_back({32'(d + 3), last, 12'((r * w + col) * c + ch), pix});
               end
               if (last) busy_until = d + 3;
               step();
               n++;
            end
         end
      end
      bus.pp_data_vld = 1'b0;
      repeat (4) step();
      check("wr_drained", exp_q.size(), 32'd0);
      check("mp_drained", mp_q.size(), 32'd0);
      check("idle_after", 32'(o_dbg_state), 32'd0);
      check("err_end", 32'(o_err), 32'd0);
   endtask

   task automatic clear_logs();
      wr_log.delete();
      mp_log.delete();
      n_done = 0;
   endtask

   task automatic check_wr(input string name, input int i, input int addr, input int data);
      logic [43:0] v;
      if (i < wr_log.size()) begin
         v = wr_log[i];
         check({name, "_addr"}, 32'(v[43:32]), 32'(addr));
         check({name, "_data"}, v[31:0], 32'(data));
      end else begin
         check({name, "_present"}, 32'd0, 32'd1);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [15:0] rc;
      int w, h, c;
      bit mp;
      bus.pp_data_vld = 1'b0;
      bus.pp_data = '0;
      rstn = 1'b0;
      repeat (3) step();
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_err", 32'(o_err), 32'd0);
      check("rst_state", 32'(o_dbg_state), 32'd0);
      check("rst_wr", 32'(bus.o_wr_vld), 32'd0);
      check("rst_mp", 32'(bus.o_mp_vld), 32'd0);
      rstn = 1'b1;
      step();

      // bypass 2x2x1, back-to-back
      clear_logs();
      run_layer(2, 2, 1, 1'b0, 0, 1'b1, -1);
      check("byp1_count", wr_log.size(), 32'd4);
      for (int i = 0; i < 4; i++) check_wr("byp1", i, i, i + 1);
      check("byp1_done", n_done, 32'd1);

      // bypass 2x1x2: channel-interleaved addresses
      clear_logs();
      run_layer(2, 1, 2, 1'b0, 0, 1'b1, -1);
      check("byp2_count", wr_log.size(), 32'd4);
      check_wr("byp2_0", 0, 0, 1);
      check_wr("byp2_1", 1, 2, 2);
      check_wr("byp2_2", 2, 1, 3);
      check_wr("byp2_3", 3, 3, 4);
      check("byp2_done", n_done, 32'd1);

      // pool 4x2x1
      clear_logs();
      run_layer(4, 2, 1, 1'b1, 0, 1'b1, -1);
      check("pool_count", wr_log.size(), 32'd2);
      check_wr("pool_0", 0, 0, 6);
      check_wr("pool_1", 1, 1, 8);
      check("pool_done", n_done, 32'd1);
      check("pool_mp_count", mp_log.size(), 32'd8);
      for (int i = 0; i < 8 && i < mp_log.size(); i++) begin
         rc = mp_log[i];
         check("pool_mp_row", 32'(rc[15:8]), 32'(i / 4));
         check("pool_mp_col", 32'(rc[7:0]), 32'(i % 4));
      end

      // invalid pool config: odd width
      q_width = 8'd3; q_height = 8'd2; q_channel_out = 5'd1; q_mp_en = 1'b1;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      check("cfg_err", 32'(o_err), 32'd2);
      check("cfg_busy", 32'(o_busy), 32'd0);
      check("cfg_state", 32'(o_dbg_state), 32'd0);
      repeat (2) step();
      check("cfg_still_idle", 32'(o_dbg_state), 32'd0);
      run_layer(2, 3, 2, 1'b0, 20, 1'b0, -1);

      // overrun: pixel while idle
      clear_logs();
      bus.pp_data_vld = 1'b1;
      bus.pp_data = $urandom;
      step();
      bus.pp_data_vld = 1'b0;
      check("ovr_err", 32'(o_err), 32'd1);
      check("ovr_state", 32'(o_dbg_state), 32'd0);
      repeat (4) step();
      check("ovr_no_wr", wr_log.size(), 32'd0);
      run_layer(4, 4, 2, 1'b1, 25, 1'b0, -1);

      // reset in the middle of a layer, then a fresh layer
      clear_logs();
      run_layer(4, 4, 2, 1'b0, 10, 1'b0, 9);
      check("abort_no_done", n_done, 32'd0);
      run_layer(4, 2, 2, 1'b1, 10, 1'b0, -1);

      // randomized layers with bubbles
      for (int k = 0; k < 10; k++) begin
         mp = 1'($urandom_range(0, 1));
         if (mp) begin
            w = 2 * $urandom_range(1, 4);
            h = 2 * $urandom_range(1, 3);
         end else begin
            w = $urandom_range(1, 8);
            h = $urandom_range(1, 6);
         end
         c = $urandom_range(1, 3);
         clear_logs();
         run_layer(w, h, c, mp, $urandom_range(0, 40), 1'b0, -1);
         check("rand_done", n_done, 32'd1);
         check("rand_count", wr_log.size(), 32'(mp ? (w * h * c) / 4 : w * h * c));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
